// File: rtl/mmio_periph_pkg.sv
// Shared definitions for the mmio_periph hub: register offsets, CTRL layout,
// reset polarity and the active-low seven-segment hex decoder.
package mmio_periph_pkg;

    // Level of rst that holds the block in reset (sampled on rising clk)
    localparam logic RST_ACT = 1'b0;

    // Word offsets, addr[4:2]
    localparam logic [2:0] OFF_SEG  = 3'd0;
    localparam logic [2:0] OFF_LED  = 3'd1;
    localparam logic [2:0] OFF_BTN  = 3'd2;
    localparam logic [2:0] OFF_EDGE = 3'd3;
    localparam logic [2:0] OFF_CTRL = 3'd4;

    // CTRL register, bit0 scan_en, bit1 irq_en, bit2 blank
    typedef struct packed {
        logic blank;
        logic irq_en;
        logic scan_en;
    } ctrl_t;

    localparam ctrl_t CTRL_RESET = '{blank: 1'b0, irq_en: 1'b0, scan_en: 1'b1};

    // Hex nibble to segments {dp,g..a}, active-low, dp off
    function automatic logic [7:0] seg_decode(input logic [3:0] nib);
        logic [7:0] s;
        case (nib)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/mmio_periph_btn_debounce.sv
// Single-button synchroniser and debouncer. A change on the synchronised
// input is accepted only after DB_CYCLES consecutive differing samples;
// rise flags the cycle in which a 0->1 change is accepted.
module btn_debounce
    import mmio_periph_pkg::*;
#(
    parameter int DB_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic state,
    output logic rise
);

    localparam int CNT_W = $clog2(DB_CYCLES);

    logic             sync1;
    logic             sync2;
    logic             flip;
    logic [CNT_W-1:0] cnt;

    assign flip = (sync2 != state) && (cnt == CNT_W'(DB_CYCLES - 1));
    assign rise = flip && !state;

    // Two-flop synchroniser, stability counter and accepted-state flop
    always_ff @(posedge clk) begin
        if (rst == RST_ACT) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            state <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            if (sync2 == state) begin
                cnt <= '0;
            end else if (flip) begin
                state <= ~state;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/mmio_periph.sv
// Memory-mapped I/O hub: seven-segment scanner, LED register, debounced
// buttons with press-edge flags, level interrupt and a registered read path
// that acknowledges every hit one cycle after the strobe.
module mmio_periph
    import mmio_periph_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] BASE_ADDR = 32'hFFFFF000,
    parameter int                N_DIGITS  = 8,
    parameter int                N_LEDS    = 16,
    parameter int                N_BTN     = 4,
    parameter int                DB_CYCLES = 1000,
    parameter int                SCAN_DIV  = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_W-1:0]   addr,
    input  logic                ce,
    input  logic                we,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   rdata,
    output logic                ack,
    output logic [7:0]          seg_o,
    output logic [N_DIGITS-1:0] an_o,
    output logic [N_LEDS-1:0]   led_o,
    input  logic [N_BTN-1:0]    btn_i,
    output logic                irq_o
);

    localparam int PSC_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int SEG_W = 4 * N_DIGITS;

    logic              hit;
    logic              wr;
    logic [2:0]        off;
    logic [SEG_W-1:0]  seg_reg;
    logic [N_LEDS-1:0] led_reg;
    logic [N_BTN-1:0]  edge_reg;
    logic [N_BTN-1:0]  edge_next;
    logic [N_BTN-1:0]  w1c;
    logic [N_BTN-1:0]  btn_state;
    logic [N_BTN-1:0]  btn_rise;
    ctrl_t             ctrl;
    ctrl_t             ctrl_next;
    logic [DATA_W-1:0] rd_val;
    logic [PSC_W-1:0]  psc;
    logic [IDX_W-1:0]  idx;
    logic [3:0]        digit;
    logic              unused_bits;

    assign hit         = ce && (addr[DATA_W-1:5] == BASE_ADDR[DATA_W-1:5]);
    assign wr          = hit && we;
    assign off         = addr[4:2];
    assign led_o       = led_reg;
    assign unused_bits = ^{addr[1:0], wdata};

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
            .clk   (clk),
            .rst   (rst),
            .btn   (btn_i[i]),
            .state (btn_state[i]),
            .rise  (btn_rise[i])
        );
    end

    // Next EDGE and CTRL values; a same-cycle press beats a W1C clear
    always_comb begin
        w1c = '0;
        if (wr && off == OFF_EDGE) w1c = wdata[N_BTN-1:0];
        edge_next = (edge_reg & ~w1c) | btn_rise;
        ctrl_next = ctrl;
        if (wr && off == OFF_CTRL) ctrl_next = ctrl_t'(wdata[2:0]);
    end

    // Register file writes
    always_ff @(posedge clk) begin
        if (rst == RST_ACT) begin
            seg_reg  <= '0;
            led_reg  <= '0;
            edge_reg <= '0;
            ctrl     <= CTRL_RESET;
        end else begin
            if (wr && off == OFF_SEG) seg_reg <= wdata[SEG_W-1:0];
            if (wr && off == OFF_LED) led_reg <= wdata[N_LEDS-1:0];
            edge_reg <= edge_next;
            ctrl     <= ctrl_next;
        end
    end

    // Read mux; unmapped offsets read zero
    always_comb begin
        rd_val = '0;
        case (off)
            OFF_SEG:  rd_val[SEG_W-1:0]  = seg_reg;
            OFF_LED:  rd_val[N_LEDS-1:0] = led_reg;
            OFF_BTN:  rd_val[N_BTN-1:0]  = btn_state;
            OFF_EDGE: rd_val[N_BTN-1:0]  = edge_reg;
            OFF_CTRL: rd_val[2:0]        = ctrl;
            default:  rd_val             = '0;
        endcase
    end

    // Bus response and interrupt; irq follows the post-write flag state
    always_ff @(posedge clk) begin
        if (rst == RST_ACT) begin
            rdata <= '0;
            ack   <= 1'b0;
            irq_o <= 1'b0;
        end else begin
            ack <= hit;
            if (hit && !we) rdata <= rd_val;
            irq_o <= ctrl_next.irq_en && (|edge_next);
        end
    end

    // Digit prescaler and index, frozen while scanning is disabled
    always_ff @(posedge clk) begin
        if (rst == RST_ACT) begin
            psc <= '0;
            idx <= '0;
        end else if (ctrl.scan_en) begin
            if (psc == PSC_W'(SCAN_DIV - 1)) begin
                psc <= '0;
                idx <= (idx == IDX_W'(N_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
            end else begin
                psc <= psc + PSC_W'(1);
            end
        end
    end

    // Nibble of the currently scanned digit
    always_comb begin
        digit = 4'h0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (idx == IDX_W'(k)) digit = seg_reg[4*k +: 4];
        end
    end

    // Registered digit enables and segments
    always_ff @(posedge clk) begin
        if (rst == RST_ACT) begin
            an_o  <= '1;
            seg_o <= 8'hFF;
        end else if (!ctrl.scan_en || ctrl.blank) begin
            an_o  <= '1;
            seg_o <= 8'hFF;
        end else begin
            an_o  <= ~(N_DIGITS'(1) << idx);
            seg_o <= seg_decode(digit);
        end
    end

endmodule
